// File: rtl/ddr5_bank_timing_tracker.sv
// Per-bank DDR5 state/timing tracker with a combinational command-legality query.
// Define DDR5_TIMING_CHECK_EN to flag (sticky err_illegal) any illegal command seen on the bus.
module ddr5_bank_timing_tracker #(
    parameter int NUM_BG       = 8,
    parameter int BANKS_PER_BG = 4,
    parameter int ROW_W        = 16,
    parameter int CNT_W        = 10,
    parameter int tRC          = 228,
    parameter int tRAS         = 152,
    parameter int tRRD_L       = 22,
    parameter int tRRD_S       = 14,
    parameter int tRP          = 74,
    parameter int tRFC         = 710,
    parameter int tCWD         = 76,
    parameter int tRCD         = 76,
    parameter int tWR          = 60,
    parameter int tRTP         = 36,
    parameter int tCCD_L       = 22,
    parameter int tCCD_S       = 14,
    parameter int tCCD_L_WR    = 94,
    parameter int tCCD_S_WR    = 14,
    parameter int tBURST       = 16,
    parameter int tCCD_L_RTW   = 30,
    parameter int tCCD_S_RTW   = 30,
    parameter int tCCD_L_WTR   = 138,
    parameter int tCCD_S_WTR   = 102,
    localparam int BG_W        = $clog2(NUM_BG),
    localparam int BA_W        = $clog2(BANKS_PER_BG),
    localparam int NB          = NUM_BG * BANKS_PER_BG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_type,
    input  logic [BG_W-1:0]  cmd_bg,
    input  logic [BA_W-1:0]  cmd_ba,
    input  logic [ROW_W-1:0] cmd_row,
    input  logic [2:0]       q_type,
    input  logic [BG_W-1:0]  q_bg,
    input  logic [BA_W-1:0]  q_ba,
    input  logic [ROW_W-1:0] q_row,
    output logic             q_ok,
    output logic             q_row_hit,
    output logic [NB-1:0]    bank_open,
    output logic             err_illegal
);
    localparam int IDX_W = $clog2(NB);
    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_RD  = 3'd2;
    localparam logic [2:0] C_WR  = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4;
    localparam logic [2:0] C_REF = 3'd5;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic {IDLE, ACTIVE} bank_st_t;
    localparam cnt_t CNT_ONE = CNT_W'(1);

    bank_st_t         bank_st  [NB];
    logic [ROW_W-1:0] open_row [NB];
    cnt_t             b_act [NB];
    cnt_t             b_pre [NB];
    cnt_t             b_rd  [NB];
    cnt_t             b_wr  [NB];
    cnt_t             g_act, g_rd, g_wr, g_ref;
    logic [BG_W-1:0]  last_act_bg, last_rd_bg, last_wr_bg;
    logic             all_pre_ok;
    logic [NB-1:0]    cmd_sel;
    logic [IDX_W-1:0] cmd_idx, q_idx;
    logic             is_act, is_rd, is_wr, is_pre, is_ref;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    // One extra bit so summed spacings such as tCWD+tBURST+tWR never wrap.
    function automatic logic elapsed_ge(input cnt_t c, input int t);
        logic [CNT_W:0] tt;
        tt = (CNT_W+1)'(t);
        return {1'b0, c} >= tt;
    endfunction

    function automatic logic [IDX_W-1:0] bank_idx(input logic [BG_W-1:0] bg, input logic [BA_W-1:0] ba);
        return IDX_W'(int'(bg) * BANKS_PER_BG + int'(ba));
    endfunction

    function automatic logic legal(input logic [2:0] t, input logic [BG_W-1:0] bg,
                                   input logic [BA_W-1:0] ba);
        logic [IDX_W-1:0] i;
        logic             ok;
        i = bank_idx(bg, ba);
        case (t)
            C_NOP: ok = 1'b1;
            C_ACT: ok = (bank_st[i] == IDLE) && elapsed_ge(b_pre[i], tRP) && elapsed_ge(b_act[i], tRC)
                        && elapsed_ge(g_act, (bg == last_act_bg) ? tRRD_L : tRRD_S)
                        && elapsed_ge(g_ref, tRFC);
            C_RD:  ok = (bank_st[i] == ACTIVE) && elapsed_ge(b_act[i], tRCD)
                        && elapsed_ge(g_rd, (bg == last_rd_bg) ? tCCD_L : tCCD_S)
                        && elapsed_ge(g_wr, (bg == last_wr_bg) ? tCCD_L_WTR : tCCD_S_WTR);
            C_WR:  ok = (bank_st[i] == ACTIVE) && elapsed_ge(b_act[i], tRCD)
                        && elapsed_ge(g_wr, (bg == last_wr_bg) ? tCCD_L_WR : tCCD_S_WR)
                        && elapsed_ge(g_rd, (bg == last_rd_bg) ? tCCD_L_RTW : tCCD_S_RTW);
            C_PRE: ok = (bank_st[i] == ACTIVE) && elapsed_ge(b_act[i], tRAS)
                        && elapsed_ge(b_rd[i], tRTP) && elapsed_ge(b_wr[i], tCWD + tBURST + tWR);
            C_REF: ok = (bank_open == '0) && all_pre_ok && elapsed_ge(g_ref, tRFC);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_comb begin
        bank_open  = '0;
        all_pre_ok = 1'b1;
        for (int i = 0; i < NB; i++) begin
            bank_open[i] = (bank_st[i] == ACTIVE);
            all_pre_ok   = all_pre_ok & elapsed_ge(b_pre[i], tRP);
        end
    end

    always_comb begin
        cmd_idx = bank_idx(cmd_bg, cmd_ba);
        cmd_sel = '0;
        for (int i = 0; i < NB; i++)
            cmd_sel[i] = cmd_valid && (cmd_idx == IDX_W'(i));
        is_act = cmd_valid && (cmd_type == C_ACT);
        is_rd  = cmd_valid && (cmd_type == C_RD);
        is_wr  = cmd_valid && (cmd_type == C_WR);
        is_pre = cmd_valid && (cmd_type == C_PRE);
        is_ref = cmd_valid && (cmd_type == C_REF);
    end

    always_comb begin
        q_idx     = bank_idx(q_bg, q_ba);
        q_ok      = legal(q_type, q_bg, q_ba);
        q_row_hit = (bank_st[q_idx] == ACTIVE) && (open_row[q_idx] == q_row);
    end

    // Counters start saturated so that every event looks infinitely old after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                bank_st[i]  <= IDLE;
                open_row[i] <= '0;
                b_act[i]    <= '1;
                b_pre[i]    <= '1;
                b_rd[i]     <= '1;
                b_wr[i]     <= '1;
            end
            g_act       <= '1;
            g_rd        <= '1;
            g_wr        <= '1;
            g_ref       <= '1;
            last_act_bg <= '0;
            last_rd_bg  <= '0;
            last_wr_bg  <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                b_act[i] <= (cmd_sel[i] && is_act) ? CNT_ONE : sat_inc(b_act[i]);
                b_pre[i] <= (cmd_sel[i] && is_pre) ? CNT_ONE : sat_inc(b_pre[i]);
                b_rd[i]  <= (cmd_sel[i] && is_rd)  ? CNT_ONE : sat_inc(b_rd[i]);
                b_wr[i]  <= (cmd_sel[i] && is_wr)  ? CNT_ONE : sat_inc(b_wr[i]);
                if (cmd_sel[i] && is_act) begin
                    bank_st[i]  <= ACTIVE;
                    open_row[i] <= cmd_row;
                end else if (cmd_sel[i] && is_pre) begin
                    bank_st[i]  <= IDLE;
                end
            end
            g_act <= is_act ? CNT_ONE : sat_inc(g_act);
            g_rd  <= is_rd  ? CNT_ONE : sat_inc(g_rd);
            g_wr  <= is_wr  ? CNT_ONE : sat_inc(g_wr);
            g_ref <= is_ref ? CNT_ONE : sat_inc(g_ref);
            if (is_act) last_act_bg <= cmd_bg;
            if (is_rd)  last_rd_bg  <= cmd_bg;
            if (is_wr)  last_wr_bg  <= cmd_bg;
        end
    end

`ifdef DDR5_TIMING_CHECK_EN
    logic cmd_legal;

    always_comb cmd_legal = legal(cmd_type, cmd_bg, cmd_ba);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
        end else if (cmd_valid && !cmd_legal) begin
            err_illegal <= 1'b1;
            $error("ddr5_bank_timing_tracker: illegal command type=%0d bg=%0d ba=%0d",
                   cmd_type, cmd_bg, cmd_ba);
        end
    end
`else
    assign err_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ddr5_bank_timing_tracker.sv
// Directed bench for ddr5_bank_timing_tracker: timing boundaries, row hit, refresh blocking, reset.
module tb_ddr5_bank_timing_tracker;
    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, REF = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [2:0]  q_type;
    logic [2:0]  q_bg;
    logic [1:0]  q_ba;
    logic [15:0] q_row;
    logic        q_ok;
    logic        q_row_hit;
    logic [31:0] bank_open;
    logic        err_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr5_bank_timing_tracker dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row),
        .q_type(q_type), .q_bg(q_bg), .q_ba(q_ba), .q_row(q_row),
        .q_ok(q_ok), .q_row_hit(q_row_hit), .bank_open(bank_open), .err_illegal(err_illegal)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the next negedge, where the issued command's elapsed counter reads 1.
    task automatic issue(input logic [2:0] t, input int bg, input int ba, input logic [15:0] row);
        cmd_type  = t;
        cmd_bg    = 3'(bg);
        cmd_ba    = 2'(ba);
        cmd_row   = row;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_type  = NOP;
    endtask

    task automatic chk_q(input string tag, input logic [2:0] t, input int bg, input int ba, input logic exp);
        q_type = t;
        q_bg   = 3'(bg);
        q_ba   = 2'(ba);
        #1;
        checks++;
        assert (q_ok === exp) else begin
            errors++;
            $error("FAIL %s q_ok=%0b expected=%0b", tag, q_ok, exp);
        end
    endtask

    task automatic chk_hit(input string tag, input int bg, input int ba, input logic [15:0] row, input logic exp);
        q_type = RD;
        q_bg   = 3'(bg);
        q_ba   = 2'(ba);
        q_row  = row;
        #1;
        checks++;
        assert (q_row_hit === exp) else begin
            errors++;
            $error("FAIL %s q_row_hit=%0b expected=%0b", tag, q_row_hit, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = NOP; cmd_bg = '0; cmd_ba = '0; cmd_row = '0;
        q_type = NOP; q_bg = '0; q_ba = '0; q_row = '0;
        wait_cyc(3);

        // Reset state
        chk_v("rst_bank_open", bank_open, 32'h0);
        chk_v("rst_err", {31'b0, err_illegal}, 32'h0);
        chk_q("rst_act_ok", ACT, 0, 0, 1'b1);
        chk_q("rst_rd_idle", RD, 0, 0, 1'b0);
        chk_q("rst_pre_idle", PRE, 0, 0, 1'b0);
        chk_q("rst_nop", NOP, 0, 0, 1'b1);
        chk_q("rst_reserved", 3'd6, 0, 0, 1'b0);
        chk_q("rst_ref_ok", REF, 0, 0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // ACT -> RD tRCD and row hit
        issue(ACT, 0, 0, 16'h0012);
        chk_v("act_bank_open", bank_open, 32'h1);
        wait_cyc(74);
        chk_q("trcd_75", RD, 0, 0, 1'b0);
        wait_cyc(1);
        chk_q("trcd_76", RD, 0, 0, 1'b1);
        chk_hit("row_hit_12", 0, 0, 16'h0012, 1'b1);
        chk_hit("row_hit_13", 0, 0, 16'h0013, 1'b0);
        chk_q("act_open_bank", ACT, 0, 0, 1'b0);

        // ACT-ACT same / different bank group
        issue(ACT, 0, 1, 16'h0001);
        wait_cyc(12);
        chk_q("trrd_s_13", ACT, 1, 0, 1'b0);
        wait_cyc(1);
        chk_q("trrd_s_14", ACT, 1, 0, 1'b1);
        chk_q("trrd_l_14", ACT, 0, 2, 1'b0);
        wait_cyc(7);
        chk_q("trrd_l_21", ACT, 0, 2, 1'b0);
        wait_cyc(1);
        chk_q("trrd_l_22", ACT, 0, 2, 1'b1);

        // WR spacing to PRE and to RD in same / different bank group
        issue(ACT, 2, 0, 16'h0020);
        wait_cyc(30);
        issue(ACT, 2, 1, 16'h0021);
        wait_cyc(30);
        issue(ACT, 3, 0, 16'h0030);
        wait_cyc(80);
        chk_v("open_5_banks", bank_open, 32'h0000_1303);
        chk_q("wr_ok", WR, 2, 0, 1'b1);
        issue(WR, 2, 0, 16'h0);
        chk_q("pre_idle_bank", PRE, 0, 3, 1'b0);
        wait_cyc(100);
        chk_q("wtr_s_101", RD, 3, 0, 1'b0);
        wait_cyc(1);
        chk_q("wtr_s_102", RD, 3, 0, 1'b1);
        wait_cyc(35);
        chk_q("wtr_l_137", RD, 2, 1, 1'b0);
        wait_cyc(1);
        chk_q("wtr_l_138", RD, 2, 1, 1'b1);
        wait_cyc(13);
        chk_q("wr2pre_151", PRE, 2, 0, 1'b0);
        wait_cyc(1);
        chk_q("wr2pre_152", PRE, 2, 0, 1'b1);

        // Precharge all, then REF and tRFC blocking
        issue(PRE, 0, 0, 16'h0);
        issue(PRE, 0, 1, 16'h0);
        issue(PRE, 2, 0, 16'h0);
        issue(PRE, 2, 1, 16'h0);
        chk_q("ref_bank_open", REF, 0, 0, 1'b0);
        chk_v("one_bank_open", bank_open, 32'h0000_1000);
        issue(PRE, 3, 0, 16'h0);
        chk_v("all_closed", bank_open, 32'h0);
        wait_cyc(72);
        chk_q("ref_trp_73", REF, 0, 0, 1'b0);
        wait_cyc(1);
        chk_q("ref_trp_74", REF, 0, 0, 1'b1);
        issue(REF, 0, 0, 16'h0);
        chk_q("ref_after_ref", REF, 0, 0, 1'b0);
        chk_q("trfc_1", ACT, 0, 0, 1'b0);
        wait_cyc(708);
        chk_q("trfc_709", ACT, 0, 0, 1'b0);
        wait_cyc(1);
        chk_q("trfc_710", ACT, 0, 0, 1'b1);

        // Illegal RD to an idle bank
        issue(RD, 5, 0, 16'h0);
        chk_v("rd_idle_no_open", bank_open, 32'h0);
`ifdef DDR5_TIMING_CHECK_EN
        chk_v("err_set", {31'b0, err_illegal}, 32'h1);
        wait_cyc(3);
        chk_v("err_sticky", {31'b0, err_illegal}, 32'h1);
`else
        chk_v("err_tied0", {31'b0, err_illegal}, 32'h0);
        wait_cyc(3);
        chk_v("err_tied0_later", {31'b0, err_illegal}, 32'h0);
`endif

        // Asynchronous reset mid-operation
        issue(ACT, 1, 1, 16'h0005);
        chk_v("pre_rst_open", bank_open, 32'h0000_0020);
        chk_hit("pre_rst_hit", 1, 1, 16'h0005, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_v("async_rst_open", bank_open, 32'h0);
        chk_v("async_rst_err", {31'b0, err_illegal}, 32'h0);
        chk_hit("async_rst_hit", 1, 1, 16'h0005, 1'b0);
        chk_q("async_rst_act", ACT, 1, 1, 1'b1);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
